// File: rtl/sample_loader_if.sv
// Operator-entry bus for sample_loader: button/value inputs in, packed X/y matrices and status out.
interface sample_loader_if #(
    parameter int ELEM_WIDTH  = 14,
    parameter int NUM_SAMPLES = 3,
    parameter int CNT_W       = $clog2(NUM_SAMPLES + 1)
);
    logic                                enter;
    logic [ELEM_WIDTH-1:0]               data_in;
    logic                                input_done;
    logic                                clear;
    logic [NUM_SAMPLES*2*ELEM_WIDTH-1:0] x_data;
    logic [NUM_SAMPLES*ELEM_WIDTH-1:0]   y_data;
    logic                                ready;
    logic                                load_done;
    logic                                error;
    logic                                degenerate;
    logic [CNT_W-1:0]                    sample_count;
    logic                                expect_y;

    modport master (
        output enter, data_in, input_done, clear,
        input  x_data, y_data, ready, load_done, error, degenerate, sample_count, expect_y
    );

    modport slave (
        input  enter, data_in, input_done, clear,
        output x_data, y_data, ready, load_done, error, degenerate, sample_count, expect_y
    );
endinterface

// File: rtl/sample_loader.sv
// Collects operator-entered (x, y) pairs into the packed design matrix X = [x 1] and vector y,
// then pulses load_done to start the downstream transpose.
module sample_loader #(
    parameter int ELEM_WIDTH  = 14,
    parameter int NUM_SAMPLES = 3,
    parameter int MAX_VALUE   = 99,
    parameter int CNT_W       = $clog2(NUM_SAMPLES + 1)
) (
    input  logic            clk,
    input  logic            rst,
    sample_loader_if.slave  bus
);
    localparam int XW = NUM_SAMPLES * 2 * ELEM_WIDTH;
    localparam int YW = NUM_SAMPLES * ELEM_WIDTH;
    localparam logic [ELEM_WIDTH-1:0] MAX_S = ELEM_WIDTH'(MAX_VALUE);
    localparam logic [CNT_W-1:0]      LAST_K = CNT_W'(NUM_SAMPLES - 1);

    typedef enum logic [1:0] {
        COLLECT_X = 2'd0,
        COLLECT_Y = 2'd1,
        DONE      = 2'd2,
        ERROR     = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              enter_q, enter_d;
    logic [XW-1:0]     x_q, x_d;
    logic [YW-1:0]     y_q, y_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ready_q, ready_d;
    logic              load_done_q, load_done_d;
    logic              error_q, error_d;
    logic              degenerate_q, degenerate_d;
    logic              expect_y_q, expect_y_d;
    logic              edge_s;
    logic              over_s;
    logic              last_s;

    // True when every x (even element of X) matches x[0]; a single sample is trivially degenerate.
    function automatic logic all_x_equal(input logic [XW-1:0] xv);
        logic res;
        res = 1'b1;
        for (int i = 1; i < NUM_SAMPLES; i++) begin
            res = res & (xv[2*i*ELEM_WIDTH +: ELEM_WIDTH] == xv[0 +: ELEM_WIDTH]);
        end
        return res;
    endfunction

    // Next-state, datapath capture and registered-output computation.
    always_comb begin
        state_d      = state_q;
        enter_d      = bus.enter;
        x_d          = x_q;
        y_d          = y_q;
        cnt_d        = cnt_q;
        ready_d      = ready_q;
        load_done_d  = 1'b0;
        error_d      = error_q;
        degenerate_d = degenerate_q;
        edge_s       = bus.enter & ~enter_q;
        over_s       = bus.data_in > MAX_S;
        last_s       = (cnt_q == LAST_K);

        if (bus.clear) begin
            state_d      = COLLECT_X;
            x_d          = '0;
            y_d          = '0;
            cnt_d        = '0;
            ready_d      = 1'b0;
            error_d      = 1'b0;
            degenerate_d = 1'b0;
        end else begin
            case (state_q)
                COLLECT_X: begin
                    if (edge_s && over_s) begin
                        state_d = ERROR;
                    end else if (edge_s) begin
                        for (int i = 0; i < NUM_SAMPLES; i++) begin
                            if (cnt_q == CNT_W'(i)) begin
                                x_d[2*i*ELEM_WIDTH +: ELEM_WIDTH]     = bus.data_in;
                                x_d[(2*i+1)*ELEM_WIDTH +: ELEM_WIDTH] = ELEM_WIDTH'(1);
                            end else begin
                                x_d = x_d;
                            end
                        end
                        state_d = bus.input_done ? ERROR : COLLECT_Y;
                    end else if (bus.input_done) begin
                        state_d = ERROR;
                    end else begin
                        state_d = COLLECT_X;
                    end
                end
                COLLECT_Y: begin
                    if (edge_s && over_s) begin
                        state_d = ERROR;
                    end else if (edge_s) begin
                        for (int i = 0; i < NUM_SAMPLES; i++) begin
                            if (cnt_q == CNT_W'(i)) begin
                                y_d[i*ELEM_WIDTH +: ELEM_WIDTH] = bus.data_in;
                            end else begin
                                y_d = y_d;
                            end
                        end
                        cnt_d = cnt_q + CNT_W'(1);
                        // Completing the final y wins over a coincident input_done.
                        if (last_s) begin
                            state_d      = DONE;
                            ready_d      = 1'b1;
                            load_done_d  = 1'b1;
                            degenerate_d = all_x_equal(x_q);
                        end else begin
                            state_d = bus.input_done ? ERROR : COLLECT_X;
                        end
                    end else if (bus.input_done) begin
                        state_d = ERROR;
                    end else begin
                        state_d = COLLECT_Y;
                    end
                end
                DONE: begin
                    state_d = DONE;
                end
                ERROR: begin
                    state_d = ERROR;
                end
                default: begin
                    state_d = ERROR;
                end
            endcase

            if (state_d == ERROR) begin
                error_d = 1'b1;
                ready_d = 1'b0;
            end else begin
                error_d = error_q;
            end
        end

        expect_y_d = (state_d == COLLECT_Y);
    end

    // State and output registers; enter_q resets high so a button held through reset is ignored.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= COLLECT_X;
            enter_q      <= 1'b1;
            x_q          <= '0;
            y_q          <= '0;
            cnt_q        <= '0;
            ready_q      <= 1'b0;
            load_done_q  <= 1'b0;
            error_q      <= 1'b0;
            degenerate_q <= 1'b0;
            expect_y_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            enter_q      <= enter_d;
            x_q          <= x_d;
            y_q          <= y_d;
            cnt_q        <= cnt_d;
            ready_q      <= ready_d;
            load_done_q  <= load_done_d;
            error_q      <= error_d;
            degenerate_q <= degenerate_d;
            expect_y_q   <= expect_y_d;
        end
    end

    assign bus.x_data       = x_q;
    assign bus.y_data       = y_q;
    assign bus.ready        = ready_q;
    assign bus.load_done    = load_done_q;
    assign bus.error        = error_q;
    assign bus.degenerate   = degenerate_q;
    assign bus.sample_count = cnt_q;
    assign bus.expect_y     = expect_y_q;
endmodule

// File: tb/tb_sample_loader.sv
// Directed self-checking bench for sample_loader with hand-computed expected values.
module tb_sample_loader;
    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   ld_count;
    int   ld_base;

    sample_loader_if #(.ELEM_WIDTH(14), .NUM_SAMPLES(3)) bus ();

    sample_loader #(.ELEM_WIDTH(14), .NUM_SAMPLES(3), .MAX_VALUE(99)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count load_done pulses seen between clock edges.
    always @(negedge clk) begin
        if (bus.load_done === 1'b1) ld_count++;
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic press(input logic [13:0] v);
        @(negedge clk);
        bus.data_in = v;
        bus.enter   = 1'b1;
        repeat (3) @(negedge clk);
        bus.enter = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_clear();
        @(negedge clk);
        bus.clear = 1'b1;
        @(negedge clk);
        bus.clear = 1'b0;
    endtask

    task automatic pulse_done();
        @(negedge clk);
        bus.input_done = 1'b1;
        @(negedge clk);
        bus.input_done = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        ld_count = 0;
        rst = 1'b0;
        bus.enter = 1'b0;
        bus.data_in = 14'd0;
        bus.input_done = 1'b0;
        bus.clear = 1'b0;

        #1;
        chk("rst_x", bus.x_data, 128'd0);
        chk("rst_ready", bus.ready, 128'd0);
        chk("rst_error", bus.error, 128'd0);
        chk("rst_cnt", bus.sample_count, 128'd0);
        chk("rst_expy", bus.expect_y, 128'd0);
        #11 rst = 1'b1;

        // Full collection 8,9 / 5,6 / 2,3
        press(14'd8); press(14'd9); press(14'd5); press(14'd6); press(14'd2);
        chk("cnt_two", bus.sample_count, 128'd2);
        @(negedge clk);
        bus.data_in = 14'd3;
        bus.enter   = 1'b1;
        chk("ready_before", bus.ready, 128'd0);
        @(negedge clk);
        chk("ready_rise", bus.ready, 128'd1);
        chk("ld_pulse", bus.load_done, 128'd1);
        chk("cnt_three", bus.sample_count, 128'd3);
        @(negedge clk);
        chk("ld_one_cycle", bus.load_done, 128'd0);
        chk("ready_held", bus.ready, 128'd1);
        bus.enter = 1'b0;
        chk("x_full", bus.x_data, {14'd1, 14'd2, 14'd1, 14'd5, 14'd1, 14'd8});
        chk("y_full", bus.y_data, {14'd3, 14'd6, 14'd9});
        chk("degen_0", bus.degenerate, 128'd0);

        // Long enter hold counts once
        do_clear();
        chk("clr_ready", bus.ready, 128'd0);
        chk("clr_x", bus.x_data, 128'd0);
        @(negedge clk);
        bus.data_in = 14'd7;
        bus.enter   = 1'b1;
        repeat (10) @(negedge clk);
        chk("hold_x", bus.x_data, {14'd1, 14'd7});
        chk("hold_expy", bus.expect_y, 128'd1);
        chk("hold_cnt", bus.sample_count, 128'd0);
        bus.enter = 1'b0;
        @(negedge clk);

        // Out-of-range x
        do_clear();
        press(14'd100);
        chk("range_err", bus.error, 128'd1);
        chk("range_x", bus.x_data, 128'd0);
        chk("range_ready", bus.ready, 128'd0);
        do_clear();
        chk("clr_err", bus.error, 128'd0);
        chk("clr_expy", bus.expect_y, 128'd0);
        chk("clr_cnt", bus.sample_count, 128'd0);

        // Early termination after one pair
        press(14'd4); press(14'd5);
        chk("early_cnt_pre", bus.sample_count, 128'd1);
        ld_base = ld_count;
        pulse_done();
        chk("early_err", bus.error, 128'd1);
        chk("early_ready", bus.ready, 128'd0);
        chk("early_cnt", bus.sample_count, 128'd1);
        chk("early_y", bus.y_data, 128'd5);
        press(14'd6);
        chk("early_no_ld", ld_count - ld_base, 128'd0);
        chk("err_sticky_x", bus.x_data, {14'd1, 14'd4});

        // Degenerate data, then DONE ignores inputs
        do_clear();
        press(14'd4); press(14'd1); press(14'd4); press(14'd2); press(14'd4); press(14'd3);
        chk("deg_ready", bus.ready, 128'd1);
        chk("deg_flag", bus.degenerate, 128'd1);
        press(14'd50);
        pulse_done();
        chk("done_x", bus.x_data, {14'd1, 14'd4, 14'd1, 14'd4, 14'd1, 14'd4});
        chk("done_y", bus.y_data, {14'd3, 14'd2, 14'd1});
        chk("done_cnt", bus.sample_count, 128'd3);
        chk("done_ready", bus.ready, 128'd1);
        chk("done_err", bus.error, 128'd0);

        // Asynchronous reset mid-collection with enter held
        do_clear();
        press(14'd1); press(14'd2); press(14'd3); press(14'd4);
        chk("pre_rst_cnt", bus.sample_count, 128'd2);
        @(negedge clk);
        bus.data_in = 14'd5;
        bus.enter   = 1'b1;
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("arst_x", bus.x_data, 128'd0);
        chk("arst_y", bus.y_data, 128'd0);
        chk("arst_cnt", bus.sample_count, 128'd0);
        chk("arst_expy", bus.expect_y, 128'd0);
        chk("arst_ready", bus.ready, 128'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("held_expy", bus.expect_y, 128'd0);
        chk("held_x", bus.x_data, 128'd0);
        bus.enter = 1'b0;
        press(14'd6);
        chk("post_rst_x", bus.x_data, {14'd1, 14'd6});
        chk("post_rst_expy", bus.expect_y, 128'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
